// File: rtl/led_bank.sv
// led_bank: memory-mapped LED output block.
//
// Drives NUM_LEDS outputs from a per-LED static level, a per-LED blink
// enable and a shared blink phase derived from a prescaled clock.  Registers
// are readable at the same bit positions they are written.
//
// Optional feature: define LED_BANK_PWM_EN to add an 8-bit DUTY register at
// address 3 that dims all LEDs together.  When the macro is undefined,
// address 3 ignores writes and reads as zero.
//
// Ports:
//   clock     system clock, rising edge
//   reset     asynchronous, active-high reset
//   cs        block select; qualifies write and read
//   write     write strobe
//   read      read strobe
//   address   register index (0 LEVEL, 1 BLINK_EN, 2 PERIOD, 3 DUTY)
//   data_in   write data
//   data_out  registered read data, zero when no read was issued
//   leds      registered LED drive, 1 = lit
//
// Bus protocol: a transfer happens on any rising edge where cs is high.  With
// write high, the addressed register takes data_in on that edge.  With read
// high, data_out holds the addressed register one cycle later and is zero on
// every other cycle.  No stall or wait state exists.  If read and write
// target the same register in one cycle, data_out shows the value from
// before the write.
//
// Register map (N = NUM_LEDS):
//   0 LEVEL     data_in[24 +: N]  static on/off per LED
//   1 BLINK_EN  data_in[N-1:0]    1 = LED follows the blink phase
//   2 PERIOD    data_in[15:0]     half-period in prescaler ticks, 0 = no blink
//   3 DUTY      data_in[7:0]      PWM duty, FF = fully on (PWM build only)

module led_bank #(
   parameter int NUM_LEDS      = 3,
   parameter int PRESCALE_BITS = 16
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                cs,
   input  logic                write,
   input  logic                read,
   input  logic [1:0]          address,
   input  logic [31:0]         data_in,
   output logic [31:0]         data_out,
   output logic [NUM_LEDS-1:0] leds
);

   localparam int N = NUM_LEDS;

   logic                     wr_en;
   logic                     rd_en;
   logic                     wr_level;
   logic                     wr_blink;
   logic                     wr_period;

   logic [N-1:0]             level;
   logic [N-1:0]             blink_en;
   logic [15:0]              period;

   logic [PRESCALE_BITS-1:0] pre_count;
   logic                     tick;
   logic [15:0]              blink_count;
   logic                     phase;

   logic                     pwm_gate;
   logic [N-1:0]             blink_gate;
   logic [31:0]              rd_word;

   // Only selected bits of data_in are stored.  The rest are folded here
   // so the unused upper bits do not appear as dangling inputs.
   logic                     unused_data_in;
   assign unused_data_in = ^data_in;

   assign wr_en     = cs & write;
   assign rd_en     = cs & read;
   assign wr_level  = wr_en & (address == 2'd0);
   assign wr_blink  = wr_en & (address == 2'd1);
   assign wr_period = wr_en & (address == 2'd2);

   // Control registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         level    <= '1;
         blink_en <= '0;
         period   <= '0;
      end else begin
         if (wr_level)  level    <= data_in[24 +: N];
         if (wr_blink)  blink_en <= data_in[N-1:0];
         if (wr_period) period   <= data_in[15:0];
      end
   end

   // Free-running prescaler.  tick marks the all-ones state, so it occurs
   // once every 2^PRESCALE_BITS clocks, on the cycle before the counter wraps.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pre_count <= '0;
      end else begin
         pre_count <= pre_count + PRESCALE_BITS'(1);
      end
   end

   assign tick = &pre_count;

   // Blink phase.  A PERIOD write restarts the half-period with the LEDs lit.
   // The restart wins over a tick on the same edge.  PERIOD = 0 parks the
   // phase at 1, so blinking LEDs show their static level.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         blink_count <= '0;
         phase       <= 1'b1;
      end else if (wr_period) begin
         blink_count <= '0;
         phase       <= 1'b1;
      end else if (period == 16'd0) begin
         blink_count <= '0;
         phase       <= 1'b1;
      end else if (tick) begin
         if (blink_count == period - 16'd1) begin
            blink_count <= '0;
            phase       <= ~phase;
         end else begin
            blink_count <= blink_count + 16'd1;
         end
      end
   end

`ifdef LED_BANK_PWM_EN
   logic [7:0] duty;
   logic [7:0] pwm_count;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         duty      <= 8'hFF;
         pwm_count <= '0;
      end else begin
         pwm_count <= pwm_count + 8'd1;
         if (wr_en && address == 2'd3) duty <= data_in[7:0];
      end
   end

   // FF is special-cased.  Otherwise the gate would drop for one of every
   // 256 clocks.
   assign pwm_gate = (duty == 8'hFF) | (pwm_count < duty);
`else
   assign pwm_gate = 1'b1;
`endif

   // Non-blinking LEDs pass their level.  Blinking LEDs also need phase.
   assign blink_gate = ~blink_en | {N{phase}};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         leds <= '1;
      end else begin
         leds <= level & blink_gate & {N{pwm_gate}};
      end
   end

   // Readback mux.  It uses the register values before this edge, so a
   // same-cycle write is not visible until the next read.
   always_comb begin
      rd_word = '0;
      case (address)
         2'd0:    rd_word[24 +: N] = level;
         2'd1:    rd_word[N-1:0]   = blink_en;
         2'd2:    rd_word[15:0]    = period;
`ifdef LED_BANK_PWM_EN
         2'd3:    rd_word[7:0]     = duty;
`endif
         default: rd_word = '0;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         data_out <= '0;
      end else begin
         data_out <= rd_en ? rd_word : 32'd0;
      end
   end

endmodule

// File: tb/tb_led_bank.sv
module tb_led_bank;

   logic        clock;
   logic        reset;
   logic        cs;
   logic        write;
   logic        read;
   logic [1:0]  address;
   logic [31:0] data_in;
   logic [31:0] data_out;
   logic [2:0]  leds;

   int total = 0;
   int bad   = 0;
   bit hi_bad = 0;

   typedef struct {
      logic        cs;
      logic [1:0]  addr;
      logic [31:0] data;
      logic [2:0]  exp_leds;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs [10];

   led_bank #(.NUM_LEDS(3), .PRESCALE_BITS(2)) dut (
      .clock    (clock),
      .reset    (reset),
      .cs       (cs),
      .write    (write),
      .read     (read),
      .address  (address),
      .data_in  (data_in),
      .data_out (data_out),
      .leds     (leds)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   // drivers
   task automatic bus_cycle(input logic c, input logic w, input logic r,
                            input logic [1:0] a, input logic [31:0] d);
      cs = c; write = w; read = r; address = a; data_in = d;
      @(posedge clock); #1;
      cs = 1'b0; write = 1'b0; read = 1'b0; address = 2'd0; data_in = 32'd0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clock); #1;
      end
   endtask

   // Waits for leds[0] to change, at most budget edges.  It also flags
   // leds[2:1] leaving 2'b11 while waiting.
   task automatic wait_toggle(input int budget, output int cycles, output bit ok);
      logic p;
      p = leds[0];
      cycles = 0;
      ok = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(posedge clock); #1;
         cycles++;
         if (leds[2:1] !== 2'b11) hi_bad = 1'b1;
         if (leds[0] !== p) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      int  cyc;
      bit  ok;
      int  lit;
      int  odd;
      int  changes;
      logic [2:0] prev;

      cs = 1'b0; write = 1'b0; read = 1'b0; address = 2'd0; data_in = 32'd0;
      reset = 1'b0;

      vecs[0] = '{1'b1, 2'd0, 32'h0500_0000, 3'b101, 32'h0500_0000};
      vecs[1] = '{1'b0, 2'd0, 32'h0700_0000, 3'b101, 32'h0500_0000};
      vecs[2] = '{1'b1, 2'd1, 32'hFFFF_FFFA, 3'b101, 32'h0000_0002};
      vecs[3] = '{1'b1, 2'd0, 32'hF8FF_FFFF, 3'b000, 32'h0000_0000};
      vecs[4] = '{1'b1, 2'd0, 32'h0600_0000, 3'b110, 32'h0600_0000};
      vecs[5] = '{1'b1, 2'd2, 32'hABCD_0000, 3'b110, 32'h0000_0000};
      vecs[6] = '{1'b1, 2'd1, 32'h0000_0005, 3'b110, 32'h0000_0005};
      vecs[7] = '{1'b1, 2'd1, 32'h0000_0000, 3'b110, 32'h0000_0000};
      vecs[8] = '{1'b1, 2'd0, 32'hFFFF_FFFF, 3'b111, 32'h0700_0000};
      vecs[9] = '{1'b0, 2'd1, 32'h0000_0007, 3'b111, 32'h0000_0000};

      // asynchronous reset before any clock edge
      #3 reset = 1'b1;
      #1;
      check("reset_leds_async", {29'd0, leds}, 32'h7);
      check("reset_dout_async", data_out, 32'h0);
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      idle(3);
      check("reset_leds_hold", {29'd0, leds}, 32'h7);
      check("reset_dout_hold", data_out, 32'h0);

      // table-driven write / readback
      for (int i = 0; i < 10; i++) begin
         bus_cycle(vecs[i].cs, 1'b1, 1'b0, vecs[i].addr, vecs[i].data);
         idle(1);
         check($sformatf("vec%0d_leds", i), {29'd0, leds}, {29'd0, vecs[i].exp_leds});
         bus_cycle(1'b1, 1'b0, 1'b1, vecs[i].addr, 32'd0);
         check($sformatf("vec%0d_read", i), data_out, vecs[i].exp_rd);
         idle(1);
         check($sformatf("vec%0d_read_clear", i), data_out, 32'h0);
      end

      // read and write in the same cycle returns the old value
      bus_cycle(1'b1, 1'b1, 1'b0, 2'd1, 32'h0000_0004);
      bus_cycle(1'b1, 1'b1, 1'b1, 2'd1, 32'h0000_0002);
      check("rw_same_old", data_out, 32'h0000_0004);
      bus_cycle(1'b1, 1'b0, 1'b1, 2'd1, 32'd0);
      check("rw_same_new", data_out, 32'h0000_0002);
      bus_cycle(1'b1, 1'b1, 1'b0, 2'd1, 32'h0000_0000);

      // blink: LEVEL=111, BLINK_EN=001, PERIOD=3, tick every 4 clocks
      bus_cycle(1'b1, 1'b1, 1'b0, 2'd0, 32'h0700_0000);
      bus_cycle(1'b1, 1'b1, 1'b0, 2'd1, 32'h0000_0001);
      bus_cycle(1'b1, 1'b1, 1'b0, 2'd2, 32'h0000_0003);
      check("blink_start_lit", {29'd0, leds}, 32'h7);
      hi_bad = 1'b0;
      wait_toggle(20, cyc, ok);
      check("blink_first_toggle", {31'd0, ok}, 32'd1);
      for (int t = 0; t < 2; t++) begin
         wait_toggle(20, cyc, ok);
         check($sformatf("blink_interval%0d", t), cyc, 32'd12);
      end
      check("blink_phase_low", {31'd0, leds[0]}, 32'd0);
      check("blink_others_lit", {31'd0, hi_bad}, 32'd0);

      // PERIOD = 0 forces the blinking LED back on
      bus_cycle(1'b1, 1'b1, 1'b0, 2'd2, 32'h0000_0000);
      check("period0_before", {31'd0, leds[0]}, 32'd0);
      idle(1);
      check("period0_after", {29'd0, leds}, 32'h7);
      idle(30);
      check("period0_steady", {29'd0, leds}, 32'h7);

      // reset during blink while phase = 0 and data_out is non-zero
      bus_cycle(1'b1, 1'b1, 1'b0, 2'd2, 32'h0000_0003);
      wait_toggle(20, cyc, ok);
      check("rst_blink_toggle", {31'd0, ok}, 32'd1);
      bus_cycle(1'b1, 1'b0, 1'b1, 2'd2, 32'd0);
      check("rst_blink_pre_read", data_out, 32'h3);
      check("rst_blink_pre_leds", {29'd0, leds}, 32'h6);
      #2 reset = 1'b1;
      #1;
      check("rst_blink_leds", {29'd0, leds}, 32'h7);
      check("rst_blink_dout", data_out, 32'h0);
      @(posedge clock);
      #1 reset = 1'b0;
      bus_cycle(1'b1, 1'b0, 1'b1, 2'd1, 32'd0);
      check("rst_blink_en_read", data_out, 32'h0);
      bus_cycle(1'b1, 1'b0, 1'b1, 2'd2, 32'd0);
      check("rst_period_read", data_out, 32'h0);
      bus_cycle(1'b1, 1'b0, 1'b1, 2'd0, 32'd0);
      check("rst_level_read", data_out, 32'h0700_0000);

`ifdef LED_BANK_PWM_EN
      bus_cycle(1'b1, 1'b0, 1'b1, 2'd3, 32'd0);
      check("duty_reset_read", data_out, 32'h0000_00FF);
      bus_cycle(1'b1, 1'b1, 1'b0, 2'd3, 32'h1234_5640);
      bus_cycle(1'b1, 1'b0, 1'b1, 2'd3, 32'd0);
      check("duty_read", data_out, 32'h0000_0040);
      idle(2);
      lit = 0; odd = 0;
      for (int k = 0; k < 256; k++) begin
         @(posedge clock); #1;
         if (leds === 3'b111) lit++;
         else if (leds !== 3'b000) odd++;
      end
      check("pwm40_lit", lit, 32'd64);
      check("pwm40_together", odd, 32'd0);
      bus_cycle(1'b1, 1'b1, 1'b0, 2'd3, 32'h0000_0000);
      idle(2);
      lit = 0;
      for (int k = 0; k < 256; k++) begin
         @(posedge clock); #1;
         if (leds !== 3'b000) lit++;
      end
      check("pwm00_off", lit, 32'd0);
      bus_cycle(1'b1, 1'b1, 1'b0, 2'd3, 32'h0000_00FF);
      idle(2);
      check("pwmff_on", {29'd0, leds}, 32'h7);
`else
      bus_cycle(1'b1, 1'b1, 1'b0, 2'd3, 32'h0000_0012);
      bus_cycle(1'b1, 1'b0, 1'b1, 2'd3, 32'd0);
      check("addr3_read_zero", data_out, 32'h0);
      changes = 0;
      prev = leds;
      for (int k = 0; k < 300; k++) begin
         @(posedge clock); #1;
         if (leds !== prev) changes++;
         prev = leds;
      end
      check("addr3_leds_const", changes, 32'd0);
      check("addr3_leds_val", {29'd0, leds}, 32'h7);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/led_bank.md
# led_bank

Memory-mapped, parametrised LED output block on the processor's peripheral bus. It drives `NUM_LEDS` outputs with a per-LED static level, per-LED blink enable, and a programmable blink period. It adds register readback and optional global PWM dimming. It replaces the fixed 3-LED latch, keeping its reset-to-all-on behaviour and top-byte-lane data placement.

## Interface
- `NUM_LEDS`, 3: number of LED outputs, legal range 1..8.
- `PRESCALE_BITS`, 16: width of the clock prescaler; one tick every 2^PRESCALE_BITS clocks, legal range 1..24.
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cs`  in  1  block select.
- `write`  in  1  write strobe, qualified by `cs`.
- `read`  in  1  read strobe, qualified by `cs`.
- `address`  in  2  register index.
- `data_in`  in  32  write data.
- `data_out`  out  32  registered read data.
- `leds`  out  `NUM_LEDS`  registered LED drive, 1 = lit.

## Operation
- Registers, where `N` = `NUM_LEDS`:
  - addr 0, LEVEL: `data_in[24 +: N]`, the static on/off per LED.
  - addr 1, BLINK_EN: `data_in[N-1:0]`; 1 = that LED blinks.
  - addr 2, PERIOD: `data_in[15:0]`, half-period in prescaler ticks.
  - addr 3, DUTY: `data_in[7:0]`; present only with the PWM feature.
- Unused `data_in` bits are ignored.
- A write occurs on a clock edge with `cs & write`. No write occurs without `cs`.
- Readback returns the same bit positions as the write, zero elsewhere.
- Prescaler: free-running `PRESCALE_BITS` counter. `tick` is asserted for one clock when the counter equals all-ones; the counter then wraps to 0.
- Blink counter, 16 bits:
  - On `tick`, if PERIOD != 0: if count == PERIOD-1, clear count and toggle `phase`; otherwise increment count.
  - PERIOD == 0: blinking stops, count is held at 0 and `phase` is held at 1.
  - Any write to PERIOD clears count and sets `phase` = 1 in the same edge.
- Per LED i: `leds[i]` <= LEVEL[i] & (BLINK_EN[i] ? phase : 1) & `pwm_gate`. A blinking LED with LEVEL = 0 stays off.
- All blinking LEDs share `phase`, so they toggle together.
- Reset values:
  - LEVEL = all ones, so `leds` = all ones.
  - BLINK_EN = 0, PERIOD = 0, DUTY = 8'hFF.
  - `phase` = 1, all counters = 0, `data_out` = 0.
- Reset asserted mid-operation returns every register, counter and output to these values immediately; no clock edge is needed.

## Timing
- Write to `leds` latency: `leds` reflects a LEVEL/BLINK_EN write on the clock edge after the write edge, i.e. 1 cycle later.
- Read latency: `data_out` is valid the cycle after a `cs & read` edge.
- `data_out` returns 0 on any edge without `cs & read`.
- Simultaneous read and write to the same address: the write commits; `data_out` returns the pre-write value.
- Blink toggle interval: PERIOD × 2^PRESCALE_BITS clocks between `phase` edges; `leds` follows 1 cycle after the toggle.
- A `tick` coinciding with a PERIOD write: the write takes priority, so count = 0 and `phase` = 1.
- Reads and writes to addr 3 without the PWM feature: writes are dropped, reads return 0.

## Configuration
- Macro: `LED_BANK_PWM_EN`.
- Defined:
  - An 8-bit PWM counter increments every clock and wraps 255 to 0.
  - `pwm_gate` = (DUTY == 8'hFF) | (pwm_count < DUTY).
  - DUTY 0 forces all LEDs off; DUTY FF means fully on.
  - DUTY is readable and writable at addr 3.
- Undefined: no PWM counter or DUTY register; `pwm_gate` = 1; addr 3 is inert.

## Test plan
- Reset: assert `reset` asynchronously mid-cycle. Required: `leds` = all ones and `data_out` = 0 with no clock edge; state holds after release.
- LEVEL write: `cs=1, write=1`, addr 0, `data_in` = 32'h0500_0000 (N = 3). Required: `leds` = 3'b101 one cycle later. The same write with `cs=0` leaves `leds` unchanged.
- Readback: write BLINK_EN = 3'b010, then read addr 1. Required: `data_out` = 32'h0000_0002 the next cycle and 0 the cycle after. For a read and write in the same cycle, the old value is returned.
- Blink (`PRESCALE_BITS` = 2): PERIOD = 3, BLINK_EN = 3'b001, LEVEL = 3'b111.
  - `leds[0]` toggles every 12 clocks.
  - `leds[2:1]` stay at 1.
  - Writing PERIOD = 0 forces `leds[0]` = 1 the next cycle.
- Reset during blink: while `phase` = 0, assert `reset`. Required: `leds` = 3'b111 immediately, and BLINK_EN reads 0 after release.
- PWM, with `LED_BANK_PWM_EN` defined, LEVEL = all ones:
  - DUTY = 8'h40: each LED is high for exactly 64 of every 256 clocks.
  - DUTY = 0: always off.
  - Without the macro: addr 3 reads 0 and `leds` stays constant.
